// File: rtl/spi_shift_engine_if.sv
// Handshake, configuration, serial and receive-buffer signals of the SPI shift engine.
// The LoopBack signal is present only when SPI_SHIFT_LOOPBACK_EN is defined.
interface spi_shift_engine_if #(
  parameter int MaxWordLen = 8,
  parameter int LW         = $clog2(MaxWordLen) + 1
);
  logic                  Start;
  logic                  Abort;
  logic [LW-1:0]         WordLenSel;
  logic                  Endiannes;
  logic                  TxEn;
  logic [MaxWordLen-1:0] DataIN;
  logic                  SampleFlg;
  logic                  ShiftFlg;
  logic                  MISO;
  logic                  MOSI;
  logic                  MOSIOE;
  logic                  Busy;
  logic                  WordDone;
  logic [MaxWordLen-1:0] RXData;
  logic                  RXValid;
  logic                  RXAck;
  logic                  Overrun;
`ifdef SPI_SHIFT_LOOPBACK_EN
  logic                  LoopBack;
`endif

  // Engine side.
  modport slave (
    input  Start, Abort, WordLenSel, Endiannes, TxEn, DataIN,
    input  SampleFlg, ShiftFlg, MISO, RXAck,
`ifdef SPI_SHIFT_LOOPBACK_EN
    input  LoopBack,
`endif
    output MOSI, MOSIOE, Busy, WordDone, RXData, RXValid, Overrun
  );

  // Control FSM / consumer side.
  modport master (
    output Start, Abort, WordLenSel, Endiannes, TxEn, DataIN,
    output SampleFlg, ShiftFlg, MISO, RXAck,
`ifdef SPI_SHIFT_LOOPBACK_EN
    output LoopBack,
`endif
    input  MOSI, MOSIOE, Busy, WordDone, RXData, RXValid, Overrun
  );
endinterface

// File: rtl/spi_shift_engine.sv
// Full-duplex SPI word shifter with bit counter, runtime word length and buffered receive.
// Optional internal MOSI->MISO loopback is compiled in with SPI_SHIFT_LOOPBACK_EN.
module spi_shift_engine #(
  parameter int   MaxWordLen = 8,
  parameter int   LW         = $clog2(MaxWordLen) + 1,
  parameter logic IdleMOSI   = 1'b0
) (
  input logic             clk,
  input logic             rstn,
  spi_shift_engine_if.slave bus
);
  localparam int IW = $clog2(MaxWordLen);
  localparam logic [LW-1:0] MaxLen = LW'(MaxWordLen);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state_q;
  logic [LW-1:0]         n_q;
  logic [LW-1:0]         cnt_q;
  logic                  msb_q;
  logic [MaxWordLen-1:0] tx_q;
  logic [MaxWordLen-1:0] rx_q;
  logic [MaxWordLen-1:0] rxdata_q;
  logic                  rxvalid_q;
  logic                  overrun_q;

  logic [LW-1:0]         len_d;
  logic [LW-1:0]         cnt_d;
  logic [IW-1:0]         top_idx;
  logic [MaxWordLen-1:0] rx_d;
  logic [MaxWordLen-1:0] rx_mask;
  logic                  tx_bit;
  logic                  mosi_int;
  logic                  sample_bit;
  logic                  busy;

  assign busy = (state_q != IDLE);

  // Only the low N bits of the received shift register belong to the word.
  for (genvar gi = 0; gi < MaxWordLen; gi++) begin : g_mask
    assign rx_mask[gi] = (LW'(gi) < n_q);
  end

  always_comb begin
    len_d = bus.WordLenSel;
    if (bus.WordLenSel == '0 || bus.WordLenSel > MaxLen) begin
      len_d = MaxLen;
    end
    top_idx  = IW'(n_q - 1'b1);
    cnt_d    = cnt_q - 1'b1;
    tx_bit   = msb_q ? tx_q[top_idx] : tx_q[0];
    mosi_int = busy ? tx_bit : IdleMOSI;
  end

`ifdef SPI_SHIFT_LOOPBACK_EN
  assign sample_bit = bus.LoopBack ? mosi_int : bus.MISO;
  assign bus.MOSI   = bus.LoopBack ? IdleMOSI : mosi_int;
  assign bus.MOSIOE = busy && bus.TxEn && !bus.LoopBack;
`else
  assign sample_bit = bus.MISO;
  assign bus.MOSI   = mosi_int;
  assign bus.MOSIOE = busy && bus.TxEn;
`endif

  // LSB-first words are assembled right-justified by inserting at bit N-1.
  always_comb begin
    if (msb_q) begin
      rx_d = {rx_q[MaxWordLen-2:0], sample_bit};
    end else begin
      rx_d          = rx_q >> 1;
      rx_d[top_idx] = sample_bit;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      n_q       <= '0;
      cnt_q     <= '0;
      msb_q     <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      rxdata_q  <= '0;
      rxvalid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (bus.RXAck) begin
        rxvalid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (bus.Start) begin
            n_q     <= len_d;
            cnt_q   <= len_d;
            msb_q   <= bus.Endiannes;
            tx_q    <= bus.DataIN;
            rx_q    <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.Abort) begin
            rx_q    <= '0;
            state_q <= IDLE;
          end else begin
            if (bus.SampleFlg) begin
              rx_q  <= rx_d;
              cnt_q <= cnt_d;
              if (cnt_d == '0) begin
                state_q <= DONE;
              end
            end
            // A shift on the final sample cycle would only disturb the last MOSI bit.
            if (bus.ShiftFlg && !(bus.SampleFlg && cnt_d == '0)) begin
              tx_q <= msb_q ? (tx_q << 1) : (tx_q >> 1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          if (!bus.Abort) begin
            rxdata_q  <= rx_q & rx_mask;
            rxvalid_q <= 1'b1;
            if (rxvalid_q && !bus.RXAck) begin
              overrun_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Busy     = busy;
  assign bus.WordDone = (state_q == DONE) && !bus.Abort;
  assign bus.RXData   = rxdata_q;
  assign bus.RXValid  = rxvalid_q;
  assign bus.Overrun  = overrun_q;
endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed self-checking bench for spi_shift_engine (MaxWordLen=8, IdleMOSI=0).
module tb_spi_shift_engine;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   tests = 0;
  int   failed = 0;

  spi_shift_engine_if #(.MaxWordLen(8)) bus ();

  spi_shift_engine #(.MaxWordLen(8), .IdleMOSI(1'b0)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one word with paired sample/shift pulses, checking each MOSI bit; returns in the DONE cycle.
  task automatic run_word(input int n, input logic msb, input logic [7:0] data,
                          input logic [7:0] pat, input string tag);
    int idx;
    bus.Start      = 1'b1;
    bus.WordLenSel = 4'(n);
    bus.Endiannes  = msb;
    bus.DataIN     = data;
    tick();
    bus.Start = 1'b0;
    for (int i = 0; i < n; i++) begin
      idx = msb ? (n - 1 - i) : i;
      check({tag, "_mosi"}, 32'(bus.MOSI), 32'(data[idx]));
      check({tag, "_wd_early"}, 32'(bus.WordDone), 32'd0);
      bus.MISO      = pat[idx];
      bus.SampleFlg = 1'b1;
      bus.ShiftFlg  = 1'b1;
      tick();
      bus.SampleFlg = 1'b0;
      bus.ShiftFlg  = 1'b0;
    end
  endtask

  initial begin
    int          cnt;
    logic        done;
    logic [7:0]  pat;
    logic [7:0]  saved;

    bus.Start = 0; bus.Abort = 0; bus.WordLenSel = 0; bus.Endiannes = 0;
    bus.TxEn = 1; bus.DataIN = 0; bus.SampleFlg = 0; bus.ShiftFlg = 0;
    bus.MISO = 0; bus.RXAck = 0;
`ifdef SPI_SHIFT_LOOPBACK_EN
    bus.LoopBack = 0;
`endif
    #12;
    check("rst_busy",    32'(bus.Busy),     32'd0);
    check("rst_mosi",    32'(bus.MOSI),     32'd0);
    check("rst_mosioe",  32'(bus.MOSIOE),   32'd0);
    check("rst_rxdata",  32'(bus.RXData),   32'd0);
    check("rst_rxvalid", 32'(bus.RXValid),  32'd0);
    check("rst_overrun", 32'(bus.Overrun),  32'd0);
    rstn = 1'b1;
    tick();

    // MSB first, N=8, 0xA5 out, 0x3C in.
    run_word(8, 1'b1, 8'hA5, 8'h3C, "msb8");
    check("msb8_wd",     32'(bus.WordDone), 32'd1);
    check("msb8_busy_d", 32'(bus.Busy),     32'd1);
    tick();
    check("msb8_rxdata",  32'(bus.RXData),   32'h3C);
    check("msb8_rxvalid", 32'(bus.RXValid),  32'd1);
    check("msb8_idle",    32'(bus.Busy),     32'd0);
    check("msb8_wd_off",  32'(bus.WordDone), 32'd0);
    bus.RXAck = 1'b1;
    tick();
    bus.RXAck = 1'b0;
    check("ack_clear", 32'(bus.RXValid), 32'd0);

    // LSB first, N=5, 0x13 out, 0x0B in.
    run_word(5, 1'b0, 8'h13, 8'h0B, "lsb5");
    check("lsb5_wd", 32'(bus.WordDone), 32'd1);
    tick();
    check("lsb5_rxdata",  32'(bus.RXData),  32'h0B);
    check("lsb5_rxvalid", 32'(bus.RXValid), 32'd1);
    check("lsb5_overrun", 32'(bus.Overrun), 32'd0);
    bus.RXAck = 1'b1;
    tick();
    bus.RXAck = 1'b0;

    // WordLenSel=0 acts as 8; sample and shift on separate cycles.
    pat = 8'h96;
    bus.Start = 1'b1; bus.WordLenSel = 4'd0; bus.Endiannes = 1'b1; bus.DataIN = 8'h81;
    tick();
    bus.Start = 1'b0;
    cnt = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      bus.MISO = pat[7 - (cnt % 8)];
      bus.SampleFlg = 1'b1;
      tick();
      bus.SampleFlg = 1'b0;
      cnt++;
      if (bus.WordDone) begin
        done = 1'b1;
      end else begin
        bus.ShiftFlg = 1'b1;
        tick();
        bus.ShiftFlg = 1'b0;
      end
    end
    check("len0_done",    32'(done), 32'd1);
    check("len0_samples", 32'(cnt),  32'd8);
    tick();
    check("len0_rxdata", 32'(bus.RXData), 32'h96);

    bus.RXAck = 1'b1;
    tick();
    bus.RXAck = 1'b0;

    // Back-to-back words: ack in DONE keeps valid without overrun, then a missed ack overruns.
    run_word(2, 1'b1, 8'h01, 8'h02, "b2b_a");
    tick();
    run_word(2, 1'b1, 8'h02, 8'h01, "b2b_b");
    bus.RXAck = 1'b1;
    tick();
    bus.RXAck = 1'b0;
    check("b2b_ack_valid",   32'(bus.RXValid), 32'd1);
    check("b2b_ack_overrun", 32'(bus.Overrun), 32'd0);
    check("b2b_ack_rxdata",  32'(bus.RXData),  32'h01);
    run_word(2, 1'b1, 8'h03, 8'h03, "b2b_c");
    tick();
    check("b2b_overrun", 32'(bus.Overrun), 32'd1);
    check("b2b_rxdata",  32'(bus.RXData),  32'h03);

    // Abort after three samples.
    saved = bus.RXData;
    bus.Start = 1'b1; bus.WordLenSel = 4'd8; bus.Endiannes = 1'b1; bus.DataIN = 8'hF0;
    tick();
    bus.Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.MISO = 1'b1; bus.SampleFlg = 1'b1; bus.ShiftFlg = 1'b1;
      tick();
      bus.SampleFlg = 1'b0; bus.ShiftFlg = 1'b0;
    end
    check("abort_busy_pre", 32'(bus.Busy), 32'd1);
    bus.Abort = 1'b1;
    tick();
    bus.Abort = 1'b0;
    check("abort_busy", 32'(bus.Busy),     32'd0);
    check("abort_wd",   32'(bus.WordDone), 32'd0);
    tick();
    check("abort_rxdata", 32'(bus.RXData), 32'(saved));
    run_word(4, 1'b0, 8'h06, 8'h09, "post_abort");
    check("post_abort_wd", 32'(bus.WordDone), 32'd1);
    tick();
    check("post_abort_rxdata", 32'(bus.RXData), 32'h09);

    // Asynchronous reset in the middle of a transfer.
    bus.Start = 1'b1; bus.WordLenSel = 4'd8; bus.Endiannes = 1'b1; bus.DataIN = 8'hFF;
    tick();
    bus.Start = 1'b0;
    check("mid_mosi",   32'(bus.MOSI),   32'd1);
    check("mid_mosioe", 32'(bus.MOSIOE), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("arst_busy",    32'(bus.Busy),    32'd0);
    check("arst_mosi",    32'(bus.MOSI),    32'd0);
    check("arst_mosioe",  32'(bus.MOSIOE),  32'd0);
    check("arst_rxdata",  32'(bus.RXData),  32'd0);
    check("arst_rxvalid", 32'(bus.RXValid), 32'd0);
    check("arst_overrun", 32'(bus.Overrun), 32'd0);
    tick();
    rstn = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
